// File: rtl/operand_writer_if.sv
// -----------------------------------------------------------------------------
// operand_writer_if
// Bundles the operand entry controls, the commit address, the two operand read
// ports and the entry status outputs of operand_writer into one port.
//   nibble_i           hex digit to append
//   push_i             append request (level)
//   commit_i           write request (level)
//   clear_i            discard entry request (level)
//   waddr_i            commit target address
//   addra_i / addrb_i  read addresses for ports A and B
//   opea_o / opeb_o    stored operands at addra_i / addrb_i
//   entry_o            word being typed
//   count_o            digits entered so far
//   full_o             all DIGITS digits entered
//   busy_o             write cycle in progress
//   done_o             one-cycle pulse after a completed write
// The slave modport is the operand_writer side; master is the driving side.
// -----------------------------------------------------------------------------
interface operand_writer_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 3
);
   localparam int DIGITS  = N / 4;
   localparam int COUNT_W = $clog2(DIGITS + 1);

   logic [3:0]         nibble_i;
   logic               push_i;
   logic               commit_i;
   logic               clear_i;
   logic [ADDR_W-1:0]  waddr_i;
   logic [ADDR_W-1:0]  addra_i;
   logic [ADDR_W-1:0]  addrb_i;
   logic [N-1:0]       opea_o;
   logic [N-1:0]       opeb_o;
   logic [N-1:0]       entry_o;
   logic [COUNT_W-1:0] count_o;
   logic               full_o;
   logic               busy_o;
   logic               done_o;

   modport slave (
      input  nibble_i, push_i, commit_i, clear_i, waddr_i, addra_i, addrb_i,
      output opea_o, opeb_o, entry_o, count_o, full_o, busy_o, done_o
   );

   modport master (
      output nibble_i, push_i, commit_i, clear_i, waddr_i, addra_i, addrb_i,
      input  opea_o, opeb_o, entry_o, count_o, full_o, busy_o, done_o
   );
endinterface

// File: rtl/operand_writer.sv
// -----------------------------------------------------------------------------
// operand_writer
// Hex operand entry and storage for the ALU board. Digits are shifted into an
// entry word one nibble per push; a commit writes the entry word into one of
// 2^ADDR_W memory words. Two combinational read ports feed the ALU.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset; clears memory and all state
//   bus    operand_writer_if.slave (controls, addresses, operands, status)
// -----------------------------------------------------------------------------
module operand_writer #(
   parameter int N      = 32,
   parameter int ADDR_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   operand_writer_if.slave  bus
);
   localparam int DIGITS  = N / 4;
   localparam int COUNT_W = $clog2(DIGITS + 1);
   localparam int DEPTH   = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_FULL,
      S_WRITE
   } state_t;

   state_t             r_state;
   logic [N-1:0]       r_entry;
   logic [COUNT_W-1:0] r_count;
   logic [ADDR_W-1:0]  r_waddr_q;
   logic [N-1:0]       r_mem [DEPTH];
   logic               r_push_q;
   logic               r_commit_q;
   logic               r_clear_q;
   logic               r_full;
   logic               r_busy;
   logic               r_done;

   logic               w_push_edge;
   logic               w_commit_edge;
   logic               w_clear_edge;
   logic [COUNT_W-1:0] w_count_inc;

   assign w_push_edge   = bus.push_i   & ~r_push_q;
   assign w_commit_edge = bus.commit_i & ~r_commit_q;
   assign w_clear_edge  = bus.clear_i  & ~r_clear_q;
   assign w_count_inc   = r_count + COUNT_W'(1);

   // NOTE: every register below, the memory included, is assigned with <= so
   // all updates use values from before the edge; the memory is built from
   // flops with reset because reset must leave every stored operand at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_entry    <= '0;
         r_count    <= '0;
         r_waddr_q  <= '0;
         r_push_q   <= 1'b0;
         r_commit_q <= 1'b0;
         r_clear_q  <= 1'b0;
         r_full     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         // Level copies track the inputs in every state, so a level held
         // through WRITE does not produce a late edge afterwards.
         r_push_q   <= bus.push_i;
         r_commit_q <= bus.commit_i;
         r_clear_q  <= bus.clear_i;
         r_done     <= 1'b0;

         case (r_state)
            S_WRITE: begin
               // Request edges arriving in this cycle are dropped.
               r_mem[r_waddr_q] <= r_entry;
               r_entry          <= '0;
               r_count          <= '0;
               r_full           <= 1'b0;
               r_busy           <= 1'b0;
               r_done           <= 1'b1;
               r_state          <= S_IDLE;
            end
            default: begin
               // Priority clear > commit > push; lower requests are lost.
               if (w_clear_edge) begin
                  r_entry <= '0;
                  r_count <= '0;
                  r_full  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_commit_edge) begin
                  r_waddr_q <= bus.waddr_i;
                  r_busy    <= 1'b1;
                  r_state   <= S_WRITE;
               end else if (w_push_edge && (r_state != S_FULL)) begin
                  r_entry <= {r_entry[N-5:0], bus.nibble_i};
                  r_count <= w_count_inc;
                  if (w_count_inc == COUNT_W'(DIGITS)) begin
                     r_full  <= 1'b1;
                     r_state <= S_FULL;
                  end else begin
                     r_state <= S_ENTRY;
                  end
               end
            end
         endcase
      end
   end

   assign bus.opea_o  = r_mem[bus.addra_i];
   assign bus.opeb_o  = r_mem[bus.addrb_i];
   assign bus.entry_o = r_entry;
   assign bus.count_o = r_count;
   assign bus.full_o  = r_full;
   assign bus.busy_o  = r_busy;
   assign bus.done_o  = r_done;
endmodule

// File: tb/tb_operand_writer.sv
// -----------------------------------------------------------------------------
// tb_operand_writer
// Self-checking bench for operand_writer (N=32, ADDR_W=3). A behavioural model
// (digit queue plus memory array) is advanced once per clock edge from the
// same inputs the DUT sees; a negedge process compares every output against
// it. Directed scenarios add literal expectations, then random stimulus runs.
// -----------------------------------------------------------------------------
module tb_operand_writer;
   localparam int N      = 32;
   localparam int ADDR_W = 3;
   localparam int DIGITS = N / 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_writer_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

   operand_writer #(.N(N), .ADDR_W(ADDR_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Behavioural model state.
   int unsigned m_q[$];
   logic [N-1:0] m_mem [DEPTH];
   bit           m_pend;
   logic [ADDR_W-1:0] m_wa;
   bit           m_done;
   bit           m_pp, m_pc, m_pk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] model_entry();
      logic [N-1:0] v = '0;
      foreach (m_q[i]) v = (v << 4) | N'(m_q[i]);
      return v;
   endfunction

   // Advance the model by one clock edge using the pre-edge inputs.
   task automatic model_step();
      bit pe, ce, ke;
      if (rst) begin
         m_q.delete();
         foreach (m_mem[i]) m_mem[i] = '0;
         m_pend = 0; m_done = 0; m_wa = '0;
         m_pp = 0; m_pc = 0; m_pk = 0;
      end else begin
         pe = bus.push_i   && !m_pp;
         ce = bus.commit_i && !m_pc;
         ke = bus.clear_i  && !m_pk;
         m_done = 0;
         if (m_pend) begin
            m_mem[m_wa] = model_entry();
            m_q.delete();
            m_done = 1;
            m_pend = 0;
         end else if (ke) begin
            m_q.delete();
         end else if (ce) begin
            m_pend = 1;
            m_wa   = bus.waddr_i;
         end else if (pe && m_q.size() < DIGITS) begin
            m_q.push_back(int'(bus.nibble_i));
         end
         m_pp = bus.push_i; m_pc = bus.commit_i; m_pk = bus.clear_i;
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs compared at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #2;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("entry_o", bus.entry_o, model_entry());
         check("count_o", N'(bus.count_o), N'(m_q.size()));
         check("full_o",  N'(bus.full_o), N'(m_q.size() == DIGITS));
         check("busy_o",  N'(bus.busy_o), N'(m_pend));
         check("done_o",  N'(bus.done_o), N'(m_done));
         check("opea_o",  bus.opea_o, m_mem[bus.addra_i]);
         check("opeb_o",  bus.opeb_o, m_mem[bus.addrb_i]);
      end
   end

   task automatic push_digit(input logic [3:0] d);
      bus.nibble_i = d;
      bus.push_i   = 1'b1;
      cycle();
      bus.push_i   = 1'b0;
      cycle();
   endtask

   // Commit pulse, then wait through WRITE and the done cycle.
   task automatic commit_to(input logic [ADDR_W-1:0] a);
      bus.waddr_i  = a;
      bus.commit_i = 1'b1;
      cycle();
      bus.commit_i = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic clear_pulse();
      bus.clear_i = 1'b1;
      cycle();
      bus.clear_i = 1'b0;
      cycle();
   endtask

   initial begin
      int done_cnt;
      bus.nibble_i = '0; bus.push_i = 0; bus.commit_i = 0; bus.clear_i = 0;
      bus.waddr_i = '0; bus.addra_i = '0; bus.addrb_i = '0;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cmp_en = 1'b1;

      // Reset state
      check("rst entry", bus.entry_o, '0);
      check("rst count", N'(bus.count_o), '0);
      check("rst full",  N'(bus.full_o), '0);
      check("rst busy",  N'(bus.busy_o), '0);
      check("rst done",  N'(bus.done_o), '0);
      check("rst opea",  bus.opea_o, '0);
      check("rst opeb",  bus.opeb_o, '0);

      // Eight digits, commit to address 3
      for (int d = 1; d <= 8; d++) push_digit(4'(d));
      check("full entry", bus.entry_o, 32'h12345678);
      check("full count", N'(bus.count_o), 32'd8);
      check("full flag",  N'(bus.full_o), 32'd1);
      bus.addra_i  = 3'd3;
      bus.waddr_i  = 3'd3;
      bus.commit_i = 1'b1;
      cycle();
      bus.commit_i = 1'b0;
      check("write busy", N'(bus.busy_o), 32'd1);
      check("write no done", N'(bus.done_o), 32'd0);
      cycle();
      check("done pulse", N'(bus.done_o), 32'd1);
      check("opea new",   bus.opea_o, 32'h12345678);
      check("entry clr",  bus.entry_o, '0);
      cycle();
      check("done end",   N'(bus.done_o), 32'd0);

      // Ninth digit ignored
      foreach (m_mem[i]) begin end
      begin
         logic [3:0] digs [9] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
         foreach (digs[i]) push_digit(digs[i]);
      end
      check("ninth entry", bus.entry_o, 32'hABCDEF01);
      check("ninth count", N'(bus.count_o), 32'd8);
      clear_pulse();
      check("clear entry", bus.entry_o, '0);

      // Partial entry and empty commit to address 5
      bus.addrb_i = 3'd5;
      push_digit(4'hA);
      push_digit(4'hB);
      commit_to(3'd5);
      check("partial opeb", bus.opeb_o, 32'h000000AB);
      commit_to(3'd5);
      check("empty opeb", bus.opeb_o, '0);

      // Push and commit together: commit wins
      bus.addra_i = 3'd6;
      push_digit(4'h7);
      bus.nibble_i = 4'h9;
      bus.push_i   = 1'b1;
      bus.commit_i = 1'b1;
      bus.waddr_i  = 3'd6;
      cycle();
      bus.push_i = 1'b0;
      bus.commit_i = 1'b0;
      cycle();
      cycle();
      check("pc opea", bus.opea_o, 32'h7);
      check("pc count", N'(bus.count_o), '0);

      // Clear and commit together: no write
      push_digit(4'h3);
      bus.clear_i  = 1'b1;
      bus.commit_i = 1'b1;
      bus.waddr_i  = 3'd6;
      cycle();
      bus.clear_i  = 1'b0;
      bus.commit_i = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         done_cnt += int'(bus.done_o);
      end
      check("cc done", N'(done_cnt), '0);
      check("cc entry", bus.entry_o, '0);
      check("cc opea", bus.opea_o, 32'h7);

      // Commit held high for 5 cycles; push edge inside WRITE
      bus.addra_i = 3'd1;
      push_digit(4'h4);
      bus.waddr_i  = 3'd1;
      bus.commit_i = 1'b1;
      cycle();
      bus.nibble_i = 4'h9;
      bus.push_i   = 1'b1;
      done_cnt = int'(bus.done_o);
      for (int i = 0; i < 5; i++) begin
         cycle();
         done_cnt += int'(bus.done_o);
      end
      check("hold done cnt", N'(done_cnt), 32'd1);
      check("hold count", N'(bus.count_o), '0);
      check("hold opea", bus.opea_o, 32'h4);
      bus.commit_i = 1'b0;
      bus.push_i   = 1'b0;
      cycle();

      // Reset during WRITE cancels the write and clears memory
      bus.addra_i = 3'd2;
      push_digit(4'h5);
      push_digit(4'h5);
      commit_to(3'd2);
      check("pre opea", bus.opea_o, 32'h55);
      push_digit(4'hF);
      push_digit(4'hF);
      bus.waddr_i  = 3'd2;
      bus.commit_i = 1'b1;
      cycle();
      check("rw busy", N'(bus.busy_o), 32'd1);
      rst = 1'b1;
      bus.commit_i = 1'b0;
      cycle();
      rst = 1'b0;
      check("rw opea", bus.opea_o, '0);
      check("rw entry", bus.entry_o, '0);
      check("rw count", N'(bus.count_o), '0);
      check("rw busy0", N'(bus.busy_o), '0);
      check("rw done", N'(bus.done_o), '0);
      cycle();
      check("rw done next", N'(bus.done_o), '0);
      check("rw opea next", bus.opea_o, '0);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         bus.push_i   = 1'($urandom_range(0, 1));
         bus.commit_i = ($urandom_range(0, 11) == 0);
         bus.clear_i  = ($urandom_range(0, 23) == 0);
         bus.nibble_i = 4'($urandom);
         bus.waddr_i  = ADDR_W'($urandom);
         bus.addra_i  = ADDR_W'($urandom);
         bus.addrb_i  = ADDR_W'($urandom);
         rst          = ($urandom_range(0, 399) == 0);
         cycle();
      end
      rst = 1'b0;
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/operand_writer.md
# operand_writer

Operand entry and storage block for the ALU board build: the write side of the 8-entry operand memories that feed the ALU's A and B inputs. The user keys a hexadecimal word one nibble at a time from switches and buttons, and the block commits the word to a chosen memory address. Two combinational read ports present stored operands to the ALU. The current entry word is exported so the existing 7-segment display path can show it while it is being typed.

## Interface
- N, 32: operand width in bits; must be a multiple of 4; DIGITS = N/4
- ADDR_W, 3: address width; memory depth = 2^ADDR_W entries
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- nibble_i  in  4  hex digit to append
- push_i  in  1  append request, level; the rising edge is detected internally
- commit_i  in  1  write request, level; the rising edge is detected internally
- clear_i  in  1  discard entry, level; the rising edge is detected internally
- waddr_i  in  ADDR_W  target address for commit
- addra_i  in  ADDR_W  read address, port A
- addrb_i  in  ADDR_W  read address, port B
- opea_o  out  N  mem[addra_i], combinational
- opeb_o  out  N  mem[addrb_i], combinational
- entry_o  out  N  word under construction, registered
- count_o  out  $clog2(DIGITS+1)  digits entered so far
- full_o  out  1  high when count_o == DIGITS
- busy_o  out  1  high in state WRITE
- done_o  out  1  one-cycle pulse after a completed write

## Operation
- Inputs push_i, commit_i and clear_i are already synchronized and debounced to clk_i upstream.
- Edge detection:
  - Each request input has a registered copy (x_q).
  - A request is "edge = x_i & ~x_q".
  - All x_q registers reset to 0.
- States:
  - IDLE: count == 0.
  - ENTRY: 0 < count < DIGITS.
  - FULL: count == DIGITS.
  - WRITE: one cycle only.
- Per-cycle priority when not in WRITE: clear > commit > push. Only the highest-priority edge is acted on; the others in that cycle are discarded.
- Push:
  - entry <= {entry[N-5:0], nibble_i} and count += 1. The first digit typed ends up most significant after DIGITS pushes.
  - IDLE goes to ENTRY; ENTRY goes to FULL when count reaches DIGITS.
  - In FULL, a push is ignored: entry and count are unchanged.
- Clear: entry <= 0, count <= 0, state <= IDLE. Memory is untouched.
- Commit (from IDLE, ENTRY or FULL):
  - waddr_q <= waddr_i; state <= WRITE.
  - A partial entry is written as is, zero-extended in the upper bits.
  - A commit from IDLE writes 0.
- WRITE (exactly one cycle):
  - At the closing edge: mem[waddr_q] <= entry, entry <= 0, count <= 0, done_o <= 1, state <= IDLE.
  - All request edges seen during WRITE are discarded. The x_q registers still update, so a held level does not retrigger afterwards.
- Reads: opea_o and opeb_o are pure combinational reads. The same address on both ports is legal.
- Reset:
  - All memory entries, entry_o, count_o, waddr_q and done_o go to 0; state goes to IDLE.
  - Reset overrides any operation in progress, including WRITE: that write does not occur.

## Timing
- Push edge sampled at edge k: entry_o and count_o are updated from edge k, i.e. visible in cycle k+1.
- Commit edge sampled at edge k:
  - busy_o is high in cycle k+1.
  - The memory write happens at edge k+1.
  - done_o is high for exactly cycle k+2, when opea_o/opeb_o at that address already show the new value.
- Minimum spacing between two commits is 2 cycles. Push throughput is one per 2 cycles, because the level must drop before the next edge.
- Reset values of outputs: entry_o = 0, count_o = 0, full_o = 0, busy_o = 0, done_o = 0, opea_o = opeb_o = 0.
- waddr_i is sampled only on the commit edge; later changes have no effect.

## Test plan
- Reset, then push 1,2,3,4,5,6,7,8 (N=32), then commit with waddr=3, addra=3 -> entry_o = 0x12345678 with count_o = 8 and full_o = 1 before the commit; done_o pulses one cycle; opea_o = 0x12345678; entry_o = 0 afterwards.
- Push 9 digits A..I-equivalent (A,B,C,D,E,F,0,1, then 2) -> the ninth push is ignored: entry_o = 0xABCDEF01, count_o = 8.
- Push 0xA, 0xB, then commit to addr 5, addrb = 5 -> opeb_o = 0x000000AB. Commit with count 0 to addr 5 -> opeb_o = 0.
- Push and commit edges in the same cycle, entry = 0x7 -> the commit wins, the digit is not appended, mem = 0x7. Clear and commit edges together -> no write, entry_o = 0, done_o stays low.
- Hold commit_i high for 5 cycles -> exactly one write and one done_o pulse. A push edge during WRITE -> discarded, count_o stays 0.
- Assert rst_i in the WRITE cycle after loading mem[2] = 0x55 and typing 0xFF -> mem[2] = 0 (cleared by reset), no done_o, all outputs 0 on the next cycle.
